// File: rtl/mac_tx_framer.sv
// Ethernet transmit framer: wraps an upstream frame body with preamble, SFD,
// zero padding and CRC-32 FCS, then holds the inter-frame gap.
module mac_tx_framer #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned MIN_FRAME    = 60,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       s_tvalid,
  input  logic [7:0] s_tdata,
  input  logic       s_tlast,
  output logic       s_tready,
  output logic       m_tvalid,
  output logic [7:0] m_tdata,
  output logic       underrun,
  output logic       frame_done
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_PRE  = 3'd1;
  localparam logic [2:0] ST_SFD  = 3'd2;
  localparam logic [2:0] ST_DATA = 3'd3;
  localparam logic [2:0] ST_PAD  = 3'd4;
  localparam logic [2:0] ST_FCS  = 3'd5;
  localparam logic [2:0] ST_IFG  = 3'd6;

  localparam logic [7:0]  PRE_LAST = 8'(PREAMBLE_LEN - 1);
  // IDLE always contributes one idle cycle, so IFG itself holds one fewer
  localparam logic [7:0]  IFG_HOLD = 8'(IFG_BYTES - 1);
  localparam logic [15:0] MIN_LEN  = 16'(MIN_FRAME);
  localparam logic [31:0] CRC_POLY = 32'hEDB88320;

  logic [2:0]  state, state_nxt;
  logic [7:0]  cnt, cnt_nxt, cnt_inc;
  logic [15:0] body_cnt, body_nxt, body_inc;
  logic [31:0] crc, crc_nxt, fcs;
  logic        tvalid_nxt, underrun_nxt, done_nxt;
  logic [7:0]  tdata_nxt;

  // Reflected CRC-32 update over one byte, LSB first
  function automatic logic [31:0] crc_byte(input logic [31:0] c_in, input logic [7:0] d);
    logic [31:0] c;
    c = c_in ^ {24'h000000, d};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
    end
    return c;
  endfunction

  assign s_tready = (state == ST_DATA);
  assign fcs      = ~crc;

  // Next-state and next-output decode
  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    body_nxt     = body_cnt;
    crc_nxt      = crc;
    tvalid_nxt   = 1'b0;
    tdata_nxt    = 8'h00;
    underrun_nxt = 1'b0;
    done_nxt     = 1'b0;
    cnt_inc      = cnt + 8'd1;
    body_inc     = (body_cnt == 16'hFFFF) ? body_cnt : body_cnt + 16'd1;

    case (state)
      ST_IDLE: begin
        if (s_tvalid) begin
          state_nxt = ST_PRE;
          cnt_nxt   = 8'd0;
        end
      end
      ST_PRE: begin
        tvalid_nxt = 1'b1;
        tdata_nxt  = 8'h55;
        cnt_nxt    = cnt_inc;
        if (cnt >= PRE_LAST) state_nxt = ST_SFD;
      end
      ST_SFD: begin
        tvalid_nxt = 1'b1;
        tdata_nxt  = 8'hD5;
        crc_nxt    = 32'hFFFFFFFF;
        body_nxt   = 16'd0;
        state_nxt  = ST_DATA;
      end
      ST_DATA: begin
        if (s_tvalid) begin
          tvalid_nxt = 1'b1;
          tdata_nxt  = s_tdata;
          crc_nxt    = crc_byte(crc, s_tdata);
          body_nxt   = body_inc;
          if (s_tlast) begin
            cnt_nxt   = 8'd0;
            state_nxt = (body_inc < MIN_LEN) ? ST_PAD : ST_FCS;
          end
        end else begin
          // Starved mid-frame: the underrun cycle already counts as one idle cycle
          underrun_nxt = 1'b1;
          cnt_nxt      = 8'd1;
          state_nxt    = (IFG_HOLD <= 8'd1) ? ST_IDLE : ST_IFG;
        end
      end
      ST_PAD: begin
        tvalid_nxt = 1'b1;
        tdata_nxt  = 8'h00;
        crc_nxt    = crc_byte(crc, 8'h00);
        body_nxt   = body_inc;
        if (body_inc >= MIN_LEN) begin
          cnt_nxt   = 8'd0;
          state_nxt = ST_FCS;
        end
      end
      ST_FCS: begin
        tvalid_nxt = 1'b1;
        cnt_nxt    = cnt_inc;
        case (cnt[1:0])
          2'd0:    tdata_nxt = fcs[7:0];
          2'd1:    tdata_nxt = fcs[15:8];
          2'd2:    tdata_nxt = fcs[23:16];
          default: tdata_nxt = fcs[31:24];
        endcase
        if (cnt[1:0] == 2'd3) begin
          done_nxt  = 1'b1;
          cnt_nxt   = 8'd0;
          state_nxt = (IFG_HOLD == 8'd0) ? ST_IDLE : ST_IFG;
        end
      end
      ST_IFG: begin
        cnt_nxt = cnt_inc;
        if (cnt_inc >= IFG_HOLD) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= 8'd0;
      body_cnt   <= 16'd0;
      crc        <= 32'hFFFFFFFF;
      m_tvalid   <= 1'b0;
      m_tdata    <= 8'h00;
      underrun   <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      body_cnt   <= body_nxt;
      crc        <= crc_nxt;
      m_tvalid   <= tvalid_nxt;
      m_tdata    <= tdata_nxt;
      underrun   <= underrun_nxt;
      frame_done <= done_nxt;
    end
  end

endmodule

// File: tb/tb_mac_tx_framer.sv
// Scoreboard bench for mac_tx_framer: default instance plus a MIN_FRAME=0
// instance used for the "123456789" check-value frame.
module tb_mac_tx_framer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       s_tvalid, s_tlast, s_tready, m_tvalid, underrun, frame_done;
  logic [7:0] s_tdata, m_tdata;
  logic       z_s_tvalid, z_s_tlast, z_s_tready, z_m_tvalid, z_underrun, z_frame_done;
  logic [7:0] z_s_tdata, z_m_tdata;

  mac_tx_framer u_dut (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(s_tvalid), .s_tdata(s_tdata), .s_tlast(s_tlast), .s_tready(s_tready),
    .m_tvalid(m_tvalid), .m_tdata(m_tdata), .underrun(underrun), .frame_done(frame_done)
  );

  mac_tx_framer #(.MIN_FRAME(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .s_tvalid(z_s_tvalid), .s_tdata(z_s_tdata), .s_tlast(z_s_tlast), .s_tready(z_s_tready),
    .m_tvalid(z_m_tvalid), .m_tdata(z_m_tdata), .underrun(z_underrun), .frame_done(z_frame_done)
  );

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  int   errors = 0;
  int   checks = 0;
  exp_t exp_q[$];
  exp_t exp0_q[$];
  int   len_q[$];
  logic [7:0] body_q[$];
  exp_t e, e0;
  int   hi_run = 0;
  int   lo_run = 0;
  bit   gap_armed = 1'b0;
  int   gap_exp = 12;
  int   underrun_seen = 0;
  int   done0_seen = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  task automatic fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h, expected nothing", name, act);
  endtask

  // Bit-serial reference CRC-32 (reflected, poly 0xEDB88320)
  function automatic logic [31:0] ref_crc(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] r;
    logic        fb;
    r = c;
    for (int b = 0; b < 8; b++) begin
      fb = r[0] ^ d[b];
      r  = {1'b0, r[31:1]};
      if (fb) r = r ^ 32'hEDB88320;
    end
    return r;
  endfunction

  task automatic build_body(input int len, input int mul, input int add);
    body_q.delete();
    for (int i = 0; i < len; i++) body_q.push_back(8'((i * mul + add) & 255));
  endtask

  // Expected wire bytes: preamble, SFD, first n_emit body bytes, and if full, pad + FCS
  task automatic push_exp(input int n_emit, input bit full);
    logic [31:0] c;
    int          n;
    c = 32'hFFFFFFFF;
    for (int i = 0; i < 7; i++) exp_q.push_back('{data: 8'h55, last: 1'b0});
    exp_q.push_back('{data: 8'hD5, last: 1'b0});
    for (int i = 0; i < n_emit; i++) begin
      exp_q.push_back('{data: body_q[i], last: 1'b0});
      c = ref_crc(c, body_q[i]);
    end
    if (full) begin
      n = n_emit;
      while (n < 60) begin
        exp_q.push_back('{data: 8'h00, last: 1'b0});
        c = ref_crc(c, 8'h00);
        n++;
      end
      c = ~c;
      exp_q.push_back('{data: c[7:0],   last: 1'b0});
      exp_q.push_back('{data: c[15:8],  last: 1'b0});
      exp_q.push_back('{data: c[23:16], last: 1'b0});
      exp_q.push_back('{data: c[31:24], last: 1'b1});
      len_q.push_back(8 + n + 4);
    end
  endtask

  // Offer body bytes until n_xfer have been accepted
  task automatic send_body(input int n_xfer, input bit keep_valid);
    int idx;
    int guard;
    idx = 0;
    guard = 0;
    while (idx < n_xfer && guard < 2000) begin
      @(negedge clk);
      s_tvalid = 1'b1;
      s_tdata  = body_q[idx];
      s_tlast  = (idx == body_q.size() - 1);
      if (s_tready) idx++;
      guard++;
    end
    if (guard >= 2000) fail("send_timeout", 32'(idx));
    if (!keep_valid) begin
      @(negedge clk);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || exp0_q.size() != 0) && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    check("drain_left", 32'(exp_q.size() + exp0_q.size()), 32'd0);
    repeat (16) @(negedge clk);
  endtask

  // Monitor for the default instance
  always @(negedge clk) begin
    if (m_tvalid) begin
      if (gap_armed && lo_run > 0) begin
        check("ifg_gap", 32'(lo_run), 32'(gap_exp));
        gap_armed = 1'b0;
      end
      lo_run = 0;
      hi_run++;
      if (exp_q.size() == 0) begin
        fail("unexpected_byte", 32'(m_tdata));
      end else begin
        e = exp_q.pop_front();
        check("wire_byte", 32'(m_tdata), 32'(e.data));
        check("frame_done", 32'(frame_done), 32'(e.last));
        if (e.last && len_q.size() != 0) check("wire_len", 32'(hi_run), 32'(len_q.pop_front()));
      end
    end else begin
      hi_run = 0;
      lo_run++;
      if (frame_done) fail("done_while_idle", 32'(frame_done));
    end
    if (underrun) begin
      underrun_seen++;
      check("underrun_tvalid", 32'(m_tvalid), 32'd0);
    end
  end

  // Monitor for the MIN_FRAME=0 instance
  always @(negedge clk) begin
    if (z_m_tvalid) begin
      if (exp0_q.size() == 0) begin
        fail("z_unexpected_byte", 32'(z_m_tdata));
      end else begin
        e0 = exp0_q.pop_front();
        check("z_wire_byte", 32'(z_m_tdata), 32'(e0.data));
        check("z_frame_done", 32'(z_frame_done), 32'(e0.last));
      end
    end else if (z_frame_done) begin
      fail("z_done_while_idle", 32'(z_frame_done));
    end
    if (z_frame_done) done0_seen++;
    if (z_underrun) fail("z_underrun", 32'(z_underrun));
  end

  initial begin
    int   idx;
    int   guard;
    int   ready_hi;
    logic [7:0] fcs0 [4];
    fcs0[0] = 8'h26; fcs0[1] = 8'h39; fcs0[2] = 8'hF4; fcs0[3] = 8'hCB;

    rst_n = 1'b0;
    s_tvalid = 1'b0; s_tdata = 8'h00; s_tlast = 1'b0;
    z_s_tvalid = 1'b0; z_s_tdata = 8'h00; z_s_tlast = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("rst_m_tdata", 32'(m_tdata), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    check("rst_frame_done", 32'(frame_done), 32'd0);
    check("rst_s_tready", 32'(s_tready), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // MIN_FRAME=0, "123456789": standard CRC-32 check value 0xCBF43926
    for (int i = 0; i < 7; i++) exp0_q.push_back('{data: 8'h55, last: 1'b0});
    exp0_q.push_back('{data: 8'hD5, last: 1'b0});
    for (int i = 0; i < 9; i++) exp0_q.push_back('{data: 8'(8'h31 + i), last: 1'b0});
    for (int i = 0; i < 4; i++) exp0_q.push_back('{data: fcs0[i], last: (i == 3)});
    idx = 0;
    guard = 0;
    while (idx < 9 && guard < 200) begin
      @(negedge clk);
      z_s_tvalid = 1'b1;
      z_s_tdata  = 8'(8'h31 + idx);
      z_s_tlast  = (idx == 8);
      if (z_s_tready) idx++;
      guard++;
    end
    if (guard >= 200) fail("z_send_timeout", 32'(idx));
    @(negedge clk);
    z_s_tvalid = 1'b0;
    z_s_tlast  = 1'b0;
    wait_drain();
    check("z_done_count", 32'(done0_seen), 32'd1);

    // 64-byte body, no padding
    build_body(64, 7, 3);
    push_exp(64, 1'b1);
    send_body(64, 1'b0);
    wait_drain();

    // 14-byte body padded to 60; s_tready stays low during PAD
    build_body(14, 13, 200);
    push_exp(14, 1'b1);
    send_body(14, 1'b0);
    ready_hi = 0;
    repeat (45) begin
      @(negedge clk);
      if (s_tready) ready_hi++;
    end
    check("ready_in_pad", 32'(ready_hi), 32'd0);
    wait_drain();

    // Back-to-back 60-byte frames with s_tvalid held high
    build_body(60, 1, 0);
    push_exp(60, 1'b1);
    send_body(60, 1'b1);
    gap_exp = 12;
    gap_armed = 1'b1;
    build_body(60, 5, 17);
    push_exp(60, 1'b1);
    send_body(60, 1'b0);
    wait_drain();
    check("b2b_gap_seen", 32'(gap_armed), 32'd0);

    // Underrun after 20 body bytes, then a clean frame after exactly one idle input cycle
    build_body(40, 3, 9);
    push_exp(20, 1'b0);
    send_body(20, 1'b0);
    gap_exp = 12;
    gap_armed = 1'b1;
    build_body(60, 11, 1);
    push_exp(60, 1'b1);
    send_body(60, 1'b0);
    wait_drain();
    check("underrun_count", 32'(underrun_seen), 32'd1);
    check("underrun_gap_seen", 32'(gap_armed), 32'd0);

    // Reset for one cycle while body byte 30 is offered
    build_body(64, 9, 77);
    push_exp(30, 1'b0);
    send_body(30, 1'b1);
    @(negedge clk);
    s_tdata = body_q[30];
    s_tlast = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_m_tvalid", 32'(m_tvalid), 32'd0);
    check("midrst_m_tdata", 32'(m_tdata), 32'd0);
    rst_n = 1'b1;
    s_tvalid = 1'b0;
    repeat (4) @(negedge clk);
    build_body(60, 2, 33);
    push_exp(60, 1'b1);
    send_body(60, 1'b0);
    wait_drain();

    check("underrun_final", 32'(underrun_seen), 32'd1);
    check("len_q_left", 32'(len_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
